// File: rtl/reg_share_pkg.sv
// Shared types and default sizing for the register-sharing arbiter slice.
package reg_share_pkg;

  // Arbiter has two states: waiting for a request, or serving one owner
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/reg_share_arb_rr_pick.sv
// Round-robin picker: finds the first set request bit at or after ptr,
// wrapping past NUM_REQ-1 back to 0.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               any,
  output logic [PW-1:0]      winner
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan offsets from farthest to nearest so the closest set bit to ptr is the last one kept
  always_comb begin
    any    = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      idx = sum[PW-1:0];
      if (req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter that lets NUM_REQ clients take turns writing one
// shared DATA_W register, at most MAX_HOLD beats per grant, with one idle
// bubble between grants.
module reg_share_arb
  import reg_share_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   data_in,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic [DATA_W-1:0]           data_out,
  output logic                        wr_valid
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_HOLD) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_HOLD - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

  arb_state_t          state_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       ptr_d;
  logic [BW-1:0]       beat_q;
  logic [BW-1:0]       beat_d;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [PW-1:0]       owner_q;
  logic [DATA_W-1:0]   data_q;
  logic                wr_valid_q;

  logic                pickAny;
  logic [PW-1:0]       pickWinner;
  logic                ownerReq;
  logic                writeEn;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pickAny),
    .winner (pickWinner)
  );

  // The owner keeps writing only while it still requests; the pointer moves just past it when the grant ends
  always_comb begin
    ownerReq = req[owner_q];
    writeEn  = (state_q == OWN) && ownerReq;
    ptr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
    beat_d   = beat_q + BW'(1);
  end

  // Grant FSM: pick in IDLE, serve beats in OWN, always fall back to IDLE for one bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      beat_q     <= '0;
      gnt_q      <= '0;
      owner_q    <= '0;
      wr_valid_q <= 1'b0;
    end else if (state_q == IDLE) begin
      wr_valid_q <= 1'b0;
      if (pickAny) begin
        gnt_q   <= NUM_REQ'(1) << pickWinner;
        owner_q <= pickWinner;
        beat_q  <= '0;
        state_q <= OWN;
      end
    end else begin
      wr_valid_q <= ownerReq;
      if (ownerReq && (beat_q != LAST_BEAT)) begin
        beat_q <= beat_d;
      end else begin
        gnt_q   <= '0;
        ptr_q   <= ptr_d;
        beat_q  <= '0;
        state_q <= IDLE;
      end
    end
  end

  // Shared data register: captures the owner's slice on every write beat, holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (writeEn) begin
      data_q <= data_in[int'(owner_q) * DATA_W +: DATA_W];
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign data_out = data_q;
  assign wr_valid = wr_valid_q;

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed bench for reg_share_arb: a MAX_HOLD=4 instance and a MAX_HOLD=1
// instance share one clock and are driven through hand-computed steps.
module tb_reg_share_arb;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic [3:0]  req, req1;
  logic [31:0] dataIn, dataIn1;
  logic [3:0]  gnt, gnt1;
  logic [1:0]  owner, owner1;
  logic [7:0]  dataOut, dataOut1;
  logic        wrValid, wrValid1;

  int checks = 0;
  int errors = 0;

  // Free-running clock; rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  reg_share_arb #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (dataIn),
    .gnt      (gnt),
    .owner    (owner),
    .data_out (dataOut),
    .wr_valid (wrValid)
  );

  reg_share_arb #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(1)) dut1 (
    .clk      (clk),
    .rst      (rst1),
    .req      (req1),
    .data_in  (dataIn1),
    .gnt      (gnt1),
    .owner    (owner1),
    .data_out (dataOut1),
    .wr_valid (wrValid1)
  );

  // Drive both request vectors, then move to 1ns after the next rising edge so outputs are settled
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] r1);
    req  = r;
    req1 = r1;
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it, and on mismatch counts the failure and reports it
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Whole directed sequence, step by step
  initial begin
    int          owners [5];
    int          o;
    logic [3:0]  expGnt;
    logic [7:0]  expData;

    owners = '{0, 1, 2, 3, 0};
    rst     = 1'b1;
    rst1    = 1'b1;
    req     = '0;
    req1    = '0;
    dataIn  = '0;
    dataIn1 = '0;
    for (int i = 0; i < 4; i++) dataIn1[i*8 +: 8] = 8'(8'h20 + i);

    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("rst_gnt",   32'(gnt),     32'h0);
    checkOutput("rst_owner", 32'(owner),   32'h0);
    checkOutput("rst_data",  32'(dataOut), 32'h0);
    checkOutput("rst_wr",    32'(wrValid), 32'h0);
    rst = 1'b0;

    $display("[TB] idle with no requests");
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("idle_gnt",  32'(gnt),     32'h0);
      checkOutput("idle_wr",   32'(wrValid), 32'h0);
      checkOutput("idle_data", 32'(dataOut), 32'h0);
    end

    $display("[TB] single persistent requester 0");
    dataIn[7:0] = 8'hA5;
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("single_grant_gnt",   32'(gnt),     32'h1);
    checkOutput("single_grant_owner", 32'(owner),   32'h0);
    checkOutput("single_grant_wr",    32'(wrValid), 32'h0);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(4'b0001, 4'b0000);
      checkOutput("single_beat_wr",   32'(wrValid), 32'h1);
      checkOutput("single_beat_data", 32'(dataOut), 32'hA5);
      checkOutput("single_beat_gnt",  32'(gnt),     (b < 3) ? 32'h1 : 32'h0);
    end
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("single_regrant_gnt", 32'(gnt),     32'h1);
    checkOutput("single_regrant_wr",  32'(wrValid), 32'h0);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("single_drop_gnt",  32'(gnt),     32'h0);
    checkOutput("single_drop_wr",   32'(wrValid), 32'h0);
    checkOutput("single_drop_data", 32'(dataOut), 32'hA5);

    $display("[TB] all four requesting, round-robin rotation");
    rst = 1'b1;
    #1;
    rst = 1'b0;
    checkOutput("pulse_data", 32'(dataOut), 32'h0);
    for (int i = 0; i < 4; i++) dataIn[i*8 +: 8] = 8'(8'h10 + i);
    for (int g = 0; g < 5; g++) begin
      o       = owners[g];
      expGnt  = 4'b0001 << o;
      expData = 8'(8'h10 + o);
      applyStimulus(4'b1111, 4'b0000);
      checkOutput("rr_grant_gnt",   32'(gnt),     32'(expGnt));
      checkOutput("rr_grant_owner", 32'(owner),   32'(o));
      checkOutput("rr_grant_wr",    32'(wrValid), 32'h0);
      for (int b = 0; b < 4; b++) begin
        applyStimulus(4'b1111, 4'b0000);
        checkOutput("rr_beat_wr",   32'(wrValid), 32'h1);
        checkOutput("rr_beat_data", 32'(dataOut), 32'(expData));
        checkOutput("rr_beat_gnt",  32'(gnt),     (b < 3) ? 32'(expGnt) : 32'h0);
      end
    end

    $display("[TB] owner 2 drops early while 3 waits");
    applyStimulus(4'b1100, 4'b0000);
    checkOutput("drop_grant_gnt",   32'(gnt),   32'h4);
    checkOutput("drop_grant_owner", 32'(owner), 32'h2);
    applyStimulus(4'b1100, 4'b0000);
    checkOutput("drop_beat1_data", 32'(dataOut), 32'h12);
    applyStimulus(4'b1100, 4'b0000);
    checkOutput("drop_beat2_data", 32'(dataOut), 32'h12);
    checkOutput("drop_beat2_wr",   32'(wrValid), 32'h1);
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("drop_end_gnt",  32'(gnt),     32'h0);
    checkOutput("drop_end_wr",   32'(wrValid), 32'h0);
    checkOutput("drop_end_data", 32'(dataOut), 32'h12);
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("drop_next_gnt",   32'(gnt),     32'h8);
    checkOutput("drop_next_owner", 32'(owner),   32'h3);
    checkOutput("drop_next_data",  32'(dataOut), 32'h12);

    $display("[TB] async reset in the middle of owner 1");
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("pre_rst_end_gnt", 32'(gnt), 32'h0);
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("pre_rst_owner", 32'(owner), 32'h1);
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("pre_rst_data", 32'(dataOut), 32'h11);
    checkOutput("pre_rst_wr",   32'(wrValid), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_gnt",   32'(gnt),     32'h0);
    checkOutput("mid_rst_data",  32'(dataOut), 32'h0);
    checkOutput("mid_rst_wr",    32'(wrValid), 32'h0);
    checkOutput("mid_rst_owner", 32'(owner),   32'h0);
    req = 4'b0110;
    #1;
    rst = 1'b0;
    applyStimulus(4'b0110, 4'b0000);
    checkOutput("post_rst_gnt",   32'(gnt),     32'h2);
    checkOutput("post_rst_owner", 32'(owner),   32'h1);
    checkOutput("post_rst_data",  32'(dataOut), 32'h0);
    applyStimulus(4'b0110, 4'b0000);
    checkOutput("post_rst_beat_data", 32'(dataOut), 32'h11);
    checkOutput("post_rst_beat_wr",   32'(wrValid), 32'h1);

    $display("[TB] MAX_HOLD=1 instance alternating 0 and 2");
    rst1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      o       = (k % 2 == 1) ? 2 : 0;
      expGnt  = 4'b0001 << o;
      expData = 8'(8'h20 + o);
      applyStimulus(4'b0000, 4'b0101);
      checkOutput("mh1_grant_gnt",   32'(gnt1),     32'(expGnt));
      checkOutput("mh1_grant_owner", 32'(owner1),   32'(o));
      checkOutput("mh1_grant_wr",    32'(wrValid1), 32'h0);
      applyStimulus(4'b0000, 4'b0101);
      checkOutput("mh1_write_wr",   32'(wrValid1), 32'h1);
      checkOutput("mh1_write_data", 32'(dataOut1), 32'(expData));
      checkOutput("mh1_write_gnt",  32'(gnt1),     32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
